// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, constants and small helpers for the 4x4 keypad scanner.
//
// Contents:
//   KEY_CODE_W, NUM_COLS, NUM_ROWS - matrix geometry and key code width
//   fsm_state_e                    - debounce FSM states (IDLE, CONFIRM, HELD)
//   scan_kind_e / scan_result_t    - classification of one full matrix scan
//   countRows / lowestRow / packKeyCode - helpers for scan classification
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KEY_CODE_W = 4;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int COL_IDX_W  = 2;
  localparam int ROW_IDX_W  = 2;

  // Index of the column whose sample closes a full scan.
  localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_kind_e;

  typedef struct packed {
    scan_kind_e              kind;
    logic [KEY_CODE_W-1:0]   code;
  } scan_result_t;

  // Number of closed contacts reported on the row returns of one column.
  function automatic logic [2:0] countRows(input logic [NUM_ROWS-1:0] rows);
    logic [2:0] total;
    total = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      total = total + {2'b00, rows[r]};
    end
    return total;
  endfunction

  // Index of the lowest set row bit; only meaningful when exactly one is set.
  function automatic logic [ROW_IDX_W-1:0] lowestRow(input logic [NUM_ROWS-1:0] rows);
    logic [ROW_IDX_W-1:0] idx;
    idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (rows[r]) begin
        idx = ROW_IDX_W'(r);
      end
    end
    return idx;
  endfunction

  // Key code is row_index*4 + col_index, which is just the two fields packed.
  function automatic logic [KEY_CODE_W-1:0] packKeyCode(input logic [ROW_IDX_W-1:0] row,
                                                        input logic [COL_IDX_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// -----------------------------------------------------------------------------
// keypad_debounce_fsm
// Accumulates the per-column row samples of one full scan, classifies the scan
// as NONE / SINGLE(code) / MULTI, and runs the debounce state machine that
// accepts a key after DEBOUNCE_SCANS consecutive identical single-key scans.
//
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   sample_i     - high in the last cycle of a column dwell (row data settled)
//   col_idx_i    - index of the column currently strobed
//   rowk_i       - active-high row returns for the strobed column
//   key_code_o   - last accepted key code, held until the next acceptance
//   key_valid_o  - one-cycle pulse in the cycle after the accepting scan end
//   key_held_o   - high while the FSM is in HELD
// -----------------------------------------------------------------------------
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_i,
  input  logic [COL_IDX_W-1:0]  col_idx_i,
  input  logic [NUM_ROWS-1:0]   rowk_i,
  output logic [KEY_CODE_W-1:0] key_code_o,
  output logic                  key_valid_o,
  output logic                  key_held_o
);

  localparam logic [3:0] DS_CNT = 4'(DEBOUNCE_SCANS);

  // Hit accumulator encoding: more than one closed contact saturates at MANY.
  localparam logic [1:0] HITS_ZERO = 2'd0;
  localparam logic [1:0] HITS_ONE  = 2'd1;
  localparam logic [1:0] HITS_MANY = 2'd2;

  logic [1:0]            hitCount_q, hitCount_d;
  logic [KEY_CODE_W-1:0] hitCode_q, hitCode_d;
  logic [2:0]            colHits;
  logic                  scanEnd;
  scan_result_t          result;

  fsm_state_e            state_q;
  logic [KEY_CODE_W-1:0] cand_q;
  logic [3:0]            cnt_q;
  logic [KEY_CODE_W-1:0] keyCode_q;
  logic                  keyValid_q;
  logic [3:0]            newCnt;
  logic                  acceptNow;

  assign scanEnd = sample_i && (col_idx_i == LAST_COL);

  // Fold the current column's sample into the running scan summary. Only
  // the first clean single hit of a scan is remembered; anything beyond that
  // pushes the scan to MANY, which later classifies as MULTI.
  always_comb begin
    colHits    = countRows(rowk_i);
    hitCount_d = hitCount_q;
    hitCode_d  = hitCode_q;
    if (sample_i && (colHits != 3'd0)) begin
      if ((hitCount_q == HITS_ZERO) && (colHits == 3'd1)) begin
        hitCount_d = HITS_ONE;
        hitCode_d  = packKeyCode(lowestRow(rowk_i), col_idx_i);
      end else begin
        hitCount_d = HITS_MANY;
      end
    end
  end

  // Scan summary registers; cleared at every scan end so the next scan
  // starts from an empty matrix picture.
  always_ff @(posedge clk) begin
    if (rst || scanEnd) begin
      hitCount_q <= HITS_ZERO;
      hitCode_q  <= '0;
    end else begin
      hitCount_q <= hitCount_d;
      hitCode_q  <= hitCode_d;
    end
  end

  // Classification of the scan that closes in this cycle (includes the
  // column 3 sample that is arriving right now).
  always_comb begin
    result.code = hitCode_d;
    case (hitCount_d)
      HITS_ZERO: result.kind = NONE;
      HITS_ONE:  result.kind = SINGLE;
      default:   result.kind = MULTI;
    endcase
  end

  // Debounce count the candidate would have after this scan: it only grows
  // while confirming the same key, otherwise a fresh candidate starts at 1.
  // The count saturates so it can never run past the acceptance threshold.
  always_comb begin
    if ((state_q == CONFIRM) && (result.code == cand_q)) begin
      newCnt = (cnt_q >= DS_CNT) ? DS_CNT : (cnt_q + 4'd1);
    end else begin
      newCnt = 4'd1;
    end
    acceptNow = (result.kind == SINGLE) && (newCnt == DS_CNT);
  end

  // Debounce FSM. Decisions are made only at scan end; key_valid is
  // registered so the pulse lands in the cycle after the accepting scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      keyCode_q  <= '0;
      keyValid_q <= 1'b0;
    end else begin
      keyValid_q <= 1'b0;
      if (scanEnd) begin
        case (state_q)
          IDLE, CONFIRM: begin
            if (result.kind == SINGLE) begin
              cand_q <= result.code;
              cnt_q  <= newCnt;
              if (acceptNow) begin
                state_q    <= HELD;
                keyCode_q  <= result.code;
                keyValid_q <= 1'b1;
              end else begin
                state_q <= CONFIRM;
              end
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (result.kind == NONE) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if ((result.kind == SINGLE) && (result.code != cand_q)) begin
              // A different key took over: confirm it from scratch.
              cand_q <= result.code;
              cnt_q  <= newCnt;
              if (acceptNow) begin
                state_q    <= HELD;
                keyCode_q  <= result.code;
                keyValid_q <= 1'b1;
              end else begin
                state_q <= CONFIRM;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign key_code_o  = keyCode_q;
  assign key_valid_o = keyValid_q;
  assign key_held_o  = (state_q == HELD);

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Drives a one-hot column strobe across a 4x4 keypad matrix, holding each
// column for SCAN_DIV cycles, and hands the settled row returns to the
// debounce FSM, which reports accepted keys.
//
// Parameters:
//   SCAN_DIV       - cycles each column is held (2..255)
//   DEBOUNCE_SCANS - identical single-key scans needed to accept (1..15)
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   rowk       - active-high row returns of the strobed column
//   columnk    - one-hot active-high column strobe
//   key_code   - accepted key (row*4 + col), held until the next acceptance
//   key_valid  - one-cycle pulse when a key is accepted
//   key_held   - high from acceptance until the key is released
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_ROWS-1:0]   rowk,
  output logic [NUM_COLS-1:0]   columnk,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam logic [7:0] DWELL_LAST = 8'(SCAN_DIV - 1);

  logic [7:0]           dwell_q;
  logic [COL_IDX_W-1:0] colIdx_q;
  logic                 sampleNow;

  // Rows are only trusted in the last dwell cycle, after the strobe settled.
  assign sampleNow = (dwell_q == DWELL_LAST);

  // Dwell counter and column index. Both wrap silently; the 2-bit column
  // index rolls from 3 back to 0 on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q  <= '0;
      colIdx_q <= '0;
    end else if (sampleNow) begin
      dwell_q  <= '0;
      colIdx_q <= colIdx_q + 2'd1;
    end else begin
      dwell_q <= dwell_q + 8'd1;
    end
  end

  // Decoding the registered index keeps the strobe strictly one-hot.
  assign columnk = NUM_COLS'(1) << colIdx_q;

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce_fsm (
    .clk         (clk),
    .rst         (rst),
    .sample_i    (sampleNow),
    .col_idx_i   (colIdx_q),
    .rowk_i      (rowk),
    .key_code_o  (key_code),
    .key_valid_o (key_valid),
    .key_held_o  (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3). A small
// keypad model turns a 16-bit pressed-key mask into row returns for whatever
// column the DUT strobes. Key bit index is row*4 + col.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rowk;
  logic [3:0]  columnk;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressMask = '0;
  int          cycleCnt = 0;
  int          pulseCount = 0;
  int          lastCode = 0;
  int          lastPulseCycle = 0;
  int          assertCount = 0;
  int          failCount = 0;
  int          scanBase = 0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rowk      (rowk),
    .columnk   (columnk),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to time pulses against presses.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Keypad matrix: a closed key connects its column strobe to its row.
  always_comb begin
    rowk = '0;
    for (int c = 0; c < 4; c++) begin
      if (columnk[c]) begin
        for (int r = 0; r < 4; r++) begin
          rowk[r] = rowk[r] | pressMask[r*4 + c];
        end
      end
    end
  end

  // Record every accepted-key pulse away from the clock edge.
  always @(negedge clk) begin
    if (key_valid) begin
      pulseCount     = pulseCount + 1;
      lastCode       = int'(key_code);
      lastPulseCycle = cycleCnt;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input int cycles);
    pressMask = mask;
    step(cycles);
  endtask

  task automatic alignScan();
    while (((cycleCnt - scanBase) % SCAN) != 0) step(1);
  endtask

  int pulsesBefore;
  int pressCycle;
  int resetRelease;
  int n;

  initial begin
    $display("[TB] keypad_scanner directed test");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_columnk", int'(columnk), 1);
    checkOutput("rst_key_code", int'(key_code), 0);
    checkOutput("rst_key_valid", int'(key_valid), 0);
    checkOutput("rst_key_held", int'(key_held), 0);
    rst = 1'b0;
    scanBase = cycleCnt;

    // Strobe sequence: 4 cycles per column, order 1,2,4,8, repeating.
    for (int i = 0; i < 64; i++) begin
      checkOutput("strobe", int'(columnk), 1 << ((i / 4) % 4));
      step(1);
    end

    // Single press of key 9 (row 2, col 1), aligned to a scan start.
    alignScan();
    pulsesBefore = pulseCount;
    pressCycle   = cycleCnt;
    applyStimulus(16'h0200, 100);
    checkOutput("press_pulses", pulseCount - pulsesBefore, 1);
    checkOutput("press_code", lastCode, 9);
    checkOutput("press_latency", lastPulseCycle - pressCycle, 48);
    checkOutput("press_held", int'(key_held), 1);
    pressMask = '0;
    n = 0;
    while (key_held && n < 40) begin
      step(1);
      n++;
    end
    checkOutput("release_delay", n, 12);
    checkOutput("code_kept", int'(key_code), 9);
    checkOutput("no_repeat", pulseCount - pulsesBefore, 1);

    // Bounce: key 9 toggles every 10 cycles; never 3 clean scans in a row.
    alignScan();
    pulsesBefore = pulseCount;
    for (int k = 0; k < 12; k++) begin
      applyStimulus((k % 2 == 0) ? 16'h0200 : 16'h0000, 10);
    end
    pressMask = '0;
    step(2 * SCAN);
    checkOutput("bounce_pulses", pulseCount - pulsesBefore, 0);
    checkOutput("bounce_held", int'(key_held), 0);

    // Multi-key: key 0 and key 15 together classify as MULTI every scan.
    alignScan();
    pulsesBefore = pulseCount;
    applyStimulus(16'h8001, 100);
    checkOutput("multi_held", int'(key_held), 0);
    checkOutput("multi_pulses", pulseCount - pulsesBefore, 0);
    applyStimulus(16'h0000, 2 * SCAN);

    // Release and repress key 5 (row 1, col 1).
    alignScan();
    pulsesBefore = pulseCount;
    pressCycle   = cycleCnt;
    applyStimulus(16'h0020, 4 * SCAN);
    checkOutput("repress_first", pulseCount - pulsesBefore, 1);
    checkOutput("repress_lat1", lastPulseCycle - pressCycle, 48);
    applyStimulus(16'h0000, 2 * SCAN);
    checkOutput("repress_released", int'(key_held), 0);
    pressCycle = cycleCnt;
    applyStimulus(16'h0020, 4 * SCAN);
    checkOutput("repress_second", pulseCount - pulsesBefore, 2);
    checkOutput("repress_code", lastCode, 5);
    checkOutput("repress_lat2", lastPulseCycle - pressCycle, 48);
    applyStimulus(16'h0000, 2 * SCAN);

    // Reset during the second confirming scan of key 9.
    alignScan();
    pulsesBefore = pulseCount;
    applyStimulus(16'h0200, 20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    resetRelease = cycleCnt;
    scanBase     = cycleCnt;
    checkOutput("midrst_columnk", int'(columnk), 1);
    checkOutput("midrst_held", int'(key_held), 0);
    checkOutput("midrst_code", int'(key_code), 0);
    checkOutput("midrst_valid", int'(key_valid), 0);
    applyStimulus(16'h0200, 40);
    checkOutput("midrst_no_early", pulseCount - pulsesBefore, 0);
    applyStimulus(16'h0200, 20);
    checkOutput("midrst_pulses", pulseCount - pulsesBefore, 1);
    checkOutput("midrst_latency", lastPulseCycle - resetRelease, 48);
    checkOutput("midrst_key", lastCode, 9);
    applyStimulus(16'h0000, 2 * SCAN);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column strobe is held; legal range 2..255.
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive identical valid full scans needed to accept a key; legal range 1..15.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rowk  input  4  keypad row returns; active-high; bit r high means a key in row r of the strobed column is closed.
REQ-006 columnk  output  4  one-hot column strobe; active-high; drives the keypad matrix.
REQ-007 key_code  output  4  accepted key, encoded as row_index*4 + col_index.
REQ-008 key_valid  output  1  one-cycle pulse; key_code is valid in that same cycle.
REQ-009 key_held  output  1  high from acceptance until release of the accepted key.

Function
REQ-010 The block SHALL drive columnk through 4'b0001 -> 0010 -> 0100 -> 1000 -> 0001, holding each value for exactly SCAN_DIV cycles; columnk SHALL never be zero or multi-hot.
REQ-011 rowk SHALL be sampled only in the last cycle of each column dwell, which allows settle time; other cycles SHALL be ignored.
REQ-012 A full scan SHALL end at the sample of column 3; the scan period is 4*SCAN_DIV cycles (16 by default).
REQ-013 Scan result:
- NONE: no row bit set in any column.
- SINGLE(code): exactly one row bit set in exactly one column.
- MULTI: anything else.
REQ-014 The FSM SHALL have three states:
- IDLE:
  - SINGLE(c) -> CONFIRM, cand=c, cnt=1.
  - MULTI or NONE -> stay in IDLE.
- CONFIRM:
  - SINGLE(cand) -> cnt+1.
  - SINGLE(other) -> cand=other, cnt=1.
  - NONE or MULTI -> IDLE.
  - When cnt reaches DEBOUNCE_SCANS -> HELD.
- HELD:
  - NONE -> IDLE.
  - SINGLE(cand) or MULTI -> stay in HELD, with no new pulse.
  - SINGLE(other) -> CONFIRM, cand=other, cnt=1.
REQ-015 On entry to HELD, key_code SHALL load cand and key_valid SHALL pulse in the first cycle after the accepting scan end; key_code SHALL hold its value until the next acceptance.
REQ-016 key_held SHALL be high exactly while the FSM is in HELD.
REQ-017 Latency from a clean, stable press to key_valid SHALL be DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 scan periods plus 1 cycle.
REQ-018 Auto-repeat is not supported: a held key SHALL produce exactly one key_valid pulse.
REQ-019 The dwell counter and the column index SHALL wrap silently.
REQ-020 The debounce counter SHALL saturate at DEBOUNCE_SCANS.

Reset
REQ-021 While rst is high at a clock edge, the block SHALL set:
- columnk=4'b0001
- key_code=4'h0
- key_valid=0
- key_held=0
- FSM=IDLE
- cnt=0
- dwell counter=0
REQ-022 Reset asserted mid-confirmation or mid-hold SHALL discard the candidate and emit no pulse.
REQ-023 Scanning SHALL restart at column 0 in the first cycle after rst deasserts.

Structure
REQ-024 Package keypad_pkg SHALL hold:
- the FSM state encoding (IDLE, CONFIRM, HELD)
- the scan-result encoding (NONE, SINGLE, MULTI)
- the key_code width constant
- the column count constant (4)
REQ-025 The column strobe and dwell counter SHALL live in the top module.
REQ-026 Scan-result classification and the FSM SHALL be one sub-module, keypad_debounce_fsm.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3 unless stated)
REQ-027 Single press: rowk=4'b0100 whenever columnk=4'b0010, held 100 cycles, then released.
- Required: exactly one key_valid pulse, with key_code=4'h9.
- Required: the pulse occurs 3-4 scan periods after press start.
- Required: key_held falls within one scan period after release.
REQ-028 Bounce: the same key toggled every 10 cycles for 120 cycles.
- Required: no key_valid pulse.
REQ-029 Multi-key: row0/col0 and row3/col3 held together for 100 cycles.
- Required: no key_valid pulse; key_held=0.
REQ-030 Release and repress: key 4'h5 (row1/col1) pressed, released for 2 scans, then pressed again.
- Required: two key_valid pulses, both with key_code=4'h5.
REQ-031 Reset mid-operation: rst pulsed for 1 cycle during the second confirming scan.
- Required: no pulse; columnk=4'b0001 on the cycle after reset.
- Required: acceptance needs 3 fresh scans.
REQ-032 Strobe check, over 64 cycles after reset:
- Required: columnk is always one-hot.
- Required: each value lasts exactly 4 cycles, in order 1, 2, 4, 8.
